muldiv_ctrl: RTL and testbench

//  Sequencer between the pipeline EX stage and the HI/LO multiply/divide unit (Mul).
//  - Accepts MULT/MULTU/DIV/DIVU/MFHI/MFLO requests.
//  - Latches operands and issues a one-cycle MUL_Start.
//  - Waits for MUL_Flag, stalls dependent requests, serves HI/LO reads, guards against a hung unit.

---
 rtl/muldiv_ctrl_pkg.sv | 38 +++
 rtl/muldiv_ctrl_if.sv | 28 ++
 rtl/muldiv_wdog.sv | 28 ++
 rtl/muldiv_ctrl.sv | 122 ++++++++++++
 tb/tb_muldiv_ctrl.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// Shared op codes, FSM encoding and decode helpers
// for the HI/LO multiply/divide sequencer.
package muldiv_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MFHI  = 3'd4,
    OP_MFLO  = 3'd5
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_DRAIN,
    S_READ
  } state_e;

  function automatic logic is_arith(logic [2:0] op);
    return !op[2];
  endfunction

  function automatic logic is_read(logic [2:0] op);
    return (op == OP_MFHI) || (op == OP_MFLO);
  endfunction

  function automatic logic is_div(logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed(logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// EX-stage request/response bundle for the
// multiply/divide sequencer.
interface muldiv_ctrl_if #(
  parameter int DW = 32
);
  logic          Req_Valid;
  logic [2:0]    Req_Op;
  logic [DW-1:0] Req_A;
  logic [DW-1:0] Req_B;
  logic          Req_Ready;
  logic          Flush;
  logic          Rsp_Valid;
  logic [DW-1:0] Rsp_Data;
  logic          Busy;
  logic          Err_Timeout;

  modport master (
    output Req_Valid, Req_Op, Req_A, Req_B, Flush,
    input  Req_Ready, Rsp_Valid, Rsp_Data,
    input  Busy, Err_Timeout
  );

  modport slave (
    input  Req_Valid, Req_Op, Req_A, Req_B, Flush,
    output Req_Ready, Rsp_Valid, Rsp_Data,
    output Busy, Err_Timeout
  );
endinterface

// File: rtl/muldiv_wdog.sv
// Watchdog for the multiply/divide unit: counts
// enabled cycles, flags the last one of the window.
module muldiv_wdog #(
  parameter int TIMEOUT = 64,
  parameter int CW      = 7
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Clr,
  input  logic En,
  output logic Tc
);

  logic [CW-1:0] count;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)
      count <= '0;
    else if (Clr)
      count <= '0;
    else if (En)
      count <= count + 1'b1;
  end

  // Tc fires in the cycle whose edge brings count to TIMEOUT
  assign Tc = En && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer between EX and the HI/LO mul/div unit:
// operand latch, start pulse, stall, reads, watchdog.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int DW      = 32,
  parameter int TIMEOUT = 64,
  parameter int CW      = 7
) (
  input  logic          Clk,
  input  logic          Reset,
  muldiv_ctrl_if.slave  bus,
  output logic          MUL_Start,
  output logic          MUL_SelMD,
  output logic          MUL_Sign,
  output logic          MUL_SelHL,
  output logic [DW-1:0] MUL_DA,
  output logic [DW-1:0] MUL_DB,
  input  logic          MUL_Flag,
  input  logic [DW-1:0] MUL_DC
);

  state_e        state, state_nxt;
  logic          busy, ready, accept;
  logic          acc_arith, acc_read;
  logic          wd_tc, err_set;
  logic          rsp_valid, err_q;
  logic [DW-1:0] rsp_data;

  muldiv_wdog #(
    .TIMEOUT(TIMEOUT),
    .CW     (CW)
  ) u_wdog (
    .Clk  (Clk),
    .Reset(Reset),
    .Clr  (!busy),
    .En   (busy),
    .Tc   (wd_tc)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    ready     = 1'b0;
    MUL_Start = 1'b0;
    err_set   = 1'b0;
    unique case (state)
      S_IDLE: begin
        ready = Reset;
        unique case (1'b1)
          acc_arith: state_nxt = S_START;
          acc_read:  state_nxt = S_READ;
          default:   state_nxt = S_IDLE;
        endcase
      end
      S_START: begin
        busy      = 1'b1;
        MUL_Start = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT, S_DRAIN: begin
        busy = 1'b1;
        // a completion in the same cycle beats both flush and timeout
        if (MUL_Flag) begin
          state_nxt = S_IDLE;
        end else if (wd_tc) begin
          err_set   = 1'b1;
          state_nxt = S_IDLE;
        end else if (state == S_WAIT && bus.Flush) begin
          state_nxt = S_DRAIN;
        end
      end
      S_READ:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign accept    = bus.Req_Valid && ready;
  assign acc_arith = accept && is_arith(bus.Req_Op);
  assign acc_read  = accept && is_read(bus.Req_Op);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      MUL_DA    <= '0;
      MUL_DB    <= '0;
      MUL_SelMD <= 1'b0;
      MUL_Sign  <= 1'b0;
      MUL_SelHL <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      err_q     <= 1'b0;
    end else begin
      if (acc_arith) begin
        MUL_DA    <= bus.Req_A;
        MUL_DB    <= bus.Req_B;
        MUL_SelMD <= is_div(bus.Req_Op);
        MUL_Sign  <= is_signed(bus.Req_Op);
      end
      if (acc_read)
        MUL_SelHL <= (bus.Req_Op == OP_MFHI);
      rsp_valid <= (state == S_READ) && !bus.Flush;
      if (state == S_READ)
        rsp_data <= MUL_DC;
      if (err_set)
        err_q <= 1'b1;
    end
  end

  assign bus.Req_Ready   = ready;
  assign bus.Busy        = busy;
  assign bus.Rsp_Valid   = rsp_valid;
  assign bus.Rsp_Data    = rsp_data;
  assign bus.Err_Timeout = err_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with a behavioural
// HI/LO unit model (fixed latency, optional hang).
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  localparam int LAT = 4;

  logic        Clk;
  logic        Reset;
  logic        MUL_Start, MUL_SelMD, MUL_Sign, MUL_SelHL;
  logic [31:0] MUL_DA, MUL_DB, MUL_DC;
  logic        MUL_Flag;

  logic [31:0] hi, lo, p_hi, p_lo;
  int          cnt;
  logic        hang;

  int n_assert = 0;
  int n_fail   = 0;

  muldiv_ctrl_if #(.DW(32)) bus ();

  muldiv_ctrl #(
    .DW(32), .TIMEOUT(64), .CW(7)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .bus      (bus),
    .MUL_Start(MUL_Start),
    .MUL_SelMD(MUL_SelMD),
    .MUL_Sign (MUL_Sign),
    .MUL_SelHL(MUL_SelHL),
    .MUL_DA   (MUL_DA),
    .MUL_DB   (MUL_DB),
    .MUL_Flag (MUL_Flag),
    .MUL_DC   (MUL_DC)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [63:0] calc(
    logic md, logic sg, logic [31:0] a, logic [31:0] b);
    logic signed [63:0] sa, sb;
    int ia, ib;
    if (!md) begin
      sa = sg ? {{32{a[31]}}, a} : {32'b0, a};
      sb = sg ? {{32{b[31]}}, b} : {32'b0, b};
      return sa * sb;
    end
    if (b == 0) return {a, 32'hFFFF_FFFF};
    if (sg) begin
      ia = a;
      ib = b;
      return {32'(ia % ib), 32'(ia / ib)};
    end
    return {a % b, a / b};
  endfunction

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      hi <= '0; lo <= '0; p_hi <= '0; p_lo <= '0;
      cnt <= 0; MUL_Flag <= 1'b0;
    end else begin
      MUL_Flag <= 1'b0;
      if (MUL_Start && !hang) begin
        {p_hi, p_lo} <= calc(MUL_SelMD, MUL_Sign, MUL_DA, MUL_DB);
        cnt <= LAT;
      end else if (cnt != 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) begin
          MUL_Flag <= 1'b1;
          hi <= p_hi;
          lo <= p_lo;
        end
      end
    end
  end

  assign MUL_DC = MUL_SelHL ? hi : lo;

  task automatic send(input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, output int stall);
    stall = 0;
    @(negedge Clk);
    bus.Req_Valid = 1'b1;
    bus.Req_Op = op;
    bus.Req_A = a;
    bus.Req_B = b;
    while (!bus.Req_Ready && stall < 200) begin
      @(negedge Clk);
      stall++;
    end
    @(posedge Clk);
    #1;
    bus.Req_Valid = 1'b0;
  endtask

  task automatic read(input logic [2:0] op, output logic [31:0] d,
                      output logic early, output logic rv,
                      output int stall);
    send(op, 32'h0, 32'h0, stall);
    early = bus.Rsp_Valid;
    @(posedge Clk);
    #1;
    rv = bus.Rsp_Valid;
    d = bus.Rsp_Data;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (bus.Busy && cyc < 200) begin
      @(posedge Clk);
      #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge Clk);
    #1;
    n_assert++;
    if ({bus.Req_Ready, bus.Busy, bus.Rsp_Valid, bus.Err_Timeout,
         MUL_Start, MUL_SelMD, MUL_Sign, MUL_SelHL} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b required 00000000",
        {bus.Req_Ready, bus.Busy, bus.Rsp_Valid, bus.Err_Timeout,
         MUL_Start, MUL_SelMD, MUL_Sign, MUL_SelHL});
    end
    n_assert++;
    if ({MUL_DA, MUL_DB, bus.Rsp_Data} !== 96'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h %h %h required 0",
        MUL_DA, MUL_DB, bus.Rsp_Data);
    end
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    n_assert++;
    if (bus.Req_Ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b required 1", bus.Req_Ready);
    end
  endtask

  task automatic test_mult;
    int st, cyc, starts;
    logic [31:0] d;
    logic early, rv;
    send(OP_MULT, 32'hFFFF_FFFE, 32'd3, st);
    n_assert++;
    if ({MUL_Start, MUL_SelMD, MUL_Sign, bus.Busy, bus.Req_Ready}
        !== 5'b10110) begin
      n_fail++;
      $display("FAIL mult_start: got %b required 10110",
        {MUL_Start, MUL_SelMD, MUL_Sign, bus.Busy, bus.Req_Ready});
    end
    n_assert++;
    if (MUL_DA !== 32'hFFFF_FFFE || MUL_DB !== 32'd3) begin
      n_fail++;
      $display("FAIL mult_ops: got %h %h required fffffffe 00000003",
        MUL_DA, MUL_DB);
    end
    starts = 1;
    cyc = 0;
    while (bus.Busy && cyc < 200) begin
      @(posedge Clk);
      #1;
      cyc++;
      if (MUL_Start) starts++;
    end
    n_assert++;
    if (starts !== 1 || cyc >= 200) begin
      n_fail++;
      $display("FAIL mult_pulses: got %0d (cyc %0d) required 1",
        starts, cyc);
    end
    read(OP_MFHI, d, early, rv, st);
    n_assert++;
    if ({early, rv} !== 2'b01 || d !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL mult_hi: got v=%b%b d=%h required 01 ffffffff",
        early, rv, d);
    end
    read(OP_MFLO, d, early, rv, st);
    n_assert++;
    if ({early, rv} !== 2'b01 || d !== 32'hFFFF_FFFA) begin
      n_fail++;
      $display("FAIL mult_lo: got v=%b%b d=%h required 01 fffffffa",
        early, rv, d);
    end
    @(posedge Clk);
    #1;
    n_assert++;
    if (bus.Rsp_Valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rsp_pulse: got %b required 0", bus.Rsp_Valid);
    end
  endtask

  task automatic test_divu_stall;
    int st;
    logic [31:0] d;
    logic early, rv;
    send(OP_DIVU, 32'd100, 32'd7, st);
    n_assert++;
    if ({MUL_SelMD, MUL_Sign} !== 2'b10) begin
      n_fail++;
      $display("FAIL divu_sel: got %b required 10", {MUL_SelMD, MUL_Sign});
    end
    read(OP_MFLO, d, early, rv, st);
    n_assert++;
    if (st < 3 || st >= 200) begin
      n_fail++;
      $display("FAIL divu_stall: got %0d cycles required 3..199", st);
    end
    n_assert++;
    if (rv !== 1'b1 || d !== 32'd14) begin
      n_fail++;
      $display("FAIL divu_lo: got v=%b d=%0d required 1 14", rv, d);
    end
    read(OP_MFHI, d, early, rv, st);
    n_assert++;
    if (rv !== 1'b1 || d !== 32'd2) begin
      n_fail++;
      $display("FAIL divu_hi: got v=%b d=%0d required 1 2", rv, d);
    end
  endtask

  task automatic test_flush;
    int st, cyc, spurious;
    logic [31:0] d;
    logic early, rv;
    send(OP_DIV, 32'hFFFF_FFEC, 32'd3, st);
    repeat (2) begin
      @(posedge Clk);
      #1;
    end
    bus.Flush = 1'b1;
    @(posedge Clk);
    #1;
    bus.Flush = 1'b0;
    n_assert++;
    if (dut.state !== S_DRAIN || bus.Busy !== 1'b1 || bus.Req_Ready !== 1'b0)
    begin
      n_fail++;
      $display("FAIL flush_drain: got st=%0d busy=%b rdy=%b required 3 1 0",
        dut.state, bus.Busy, bus.Req_Ready);
    end
    spurious = 0;
    cyc = 0;
    while (bus.Busy && cyc < 200) begin
      @(posedge Clk);
      #1;
      cyc++;
      if (bus.Rsp_Valid) spurious++;
    end
    n_assert++;
    if (spurious !== 0 || cyc >= 200) begin
      n_fail++;
      $display("FAIL flush_rsp: got %0d pulses (cyc %0d) required 0",
        spurious, cyc);
    end
    send(OP_MULT, 32'd5, 32'd6, st);
    wait_idle(cyc);
    read(OP_MFLO, d, early, rv, st);
    n_assert++;
    if (rv !== 1'b1 || d !== 32'd30) begin
      n_fail++;
      $display("FAIL flush_next: got v=%b d=%0d required 1 30", rv, d);
    end
  endtask

  task automatic test_flush_read;
    int st;
    send(OP_MFLO, 32'h0, 32'h0, st);
    bus.Flush = 1'b1;
    @(posedge Clk);
    #1;
    bus.Flush = 1'b0;
    n_assert++;
    if (bus.Rsp_Valid !== 1'b0 || bus.Req_Ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_read: got v=%b rdy=%b required 0 1",
        bus.Rsp_Valid, bus.Req_Ready);
    end
  endtask

  task automatic test_bad_op;
    int st;
    send(3'd6, 32'h1, 32'h2, st);
    n_assert++;
    if ({bus.Busy, MUL_Start, bus.Req_Ready} !== 3'b001 || st != 0) begin
      n_fail++;
      $display("FAIL bad_op: got %b stall %0d required 001 0",
        {bus.Busy, MUL_Start, bus.Req_Ready}, st);
    end
    @(posedge Clk);
    #1;
    n_assert++;
    if (bus.Rsp_Valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_op_rsp: got %b required 0", bus.Rsp_Valid);
    end
  endtask

  task automatic test_timeout;
    int st, n;
    logic [31:0] d;
    logic early, rv;
    hang = 1'b1;
    send(OP_MULT, 32'd1, 32'd1, st);
    n = 0;
    while (!bus.Err_Timeout && n < 100) begin
      @(posedge Clk);
      #1;
      n++;
    end
    n_assert++;
    if (n !== 64) begin
      n_fail++;
      $display("FAIL timeout_cycle: got %0d required 64", n);
    end
    n_assert++;
    if (bus.Busy !== 1'b0 || bus.Req_Ready !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_idle: got busy=%b rdy=%b required 0 1",
        bus.Busy, bus.Req_Ready);
    end
    hang = 1'b0;
    read(OP_MFLO, d, early, rv, st);
    n_assert++;
    if (rv !== 1'b1 || d !== 32'd30 || bus.Err_Timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_read: got v=%b d=%0d err=%b required 1 30 1",
        rv, d, bus.Err_Timeout);
    end
  endtask

  task automatic test_reset_mid;
    int st, cyc;
    logic [31:0] d;
    logic early, rv;
    send(OP_MULT, 32'd7, 32'd9, st);
    @(posedge Clk);
    #2;
    Reset = 1'b0;
    #1;
    n_assert++;
    if ({bus.Req_Ready, bus.Busy, bus.Rsp_Valid, bus.Err_Timeout,
         MUL_Start, MUL_SelMD, MUL_Sign, MUL_SelHL} !== 8'h00 ||
        {MUL_DA, MUL_DB, bus.Rsp_Data} !== 96'h0) begin
      n_fail++;
      $display("FAIL reset_mid: got %b %h %h required 0",
        {bus.Req_Ready, bus.Busy, bus.Rsp_Valid, bus.Err_Timeout,
         MUL_Start, MUL_SelMD, MUL_Sign, MUL_SelHL}, MUL_DA, MUL_DB);
    end
    @(negedge Clk);
    Reset = 1'b1;
    send(OP_MULTU, 32'd2, 32'd3, st);
    wait_idle(cyc);
    read(OP_MFLO, d, early, rv, st);
    n_assert++;
    if (rv !== 1'b1 || d !== 32'd6) begin
      n_fail++;
      $display("FAIL reset_multu: got v=%b d=%0d required 1 6", rv, d);
    end
  endtask

  task automatic test_back_to_back;
    int acc, starts, unstable, cyc, st;
    logic rdy;
    logic [31:0] d;
    logic early, rv;
    acc = 0; starts = 0; unstable = 0; cyc = 0;
    @(negedge Clk);
    bus.Req_Valid = 1'b1;
    bus.Req_Op = OP_MULT;
    bus.Req_A = 32'd3;
    bus.Req_B = 32'd4;
    while (cyc < 100 && !(acc == 2 && !bus.Busy)) begin
      rdy = bus.Req_Valid && bus.Req_Ready;
      @(posedge Clk);
      #1;
      cyc++;
      if (rdy) begin
        acc++;
        if (acc == 1) begin
          bus.Req_A = 32'h10;
          bus.Req_B = 32'h20;
        end else begin
          bus.Req_Valid = 1'b0;
        end
      end
      if (MUL_Start) starts++;
      if (bus.Busy &&
          (MUL_DA !== (acc == 1 ? 32'd3 : 32'h10) ||
           MUL_DB !== (acc == 1 ? 32'd4 : 32'h20)))
        unstable++;
      @(negedge Clk);
    end
    bus.Req_Valid = 1'b0;
    n_assert++;
    if (acc !== 2 || starts !== 2 || cyc >= 100) begin
      n_fail++;
      $display("FAIL b2b_starts: got acc=%0d starts=%0d required 2 2",
        acc, starts);
    end
    n_assert++;
    if (unstable !== 0) begin
      n_fail++;
      $display("FAIL b2b_hold: got %0d unstable cycles required 0",
        unstable);
    end
    read(OP_MFLO, d, early, rv, st);
    n_assert++;
    if (rv !== 1'b1 || d !== 32'h200) begin
      n_fail++;
      $display("FAIL b2b_lo: got v=%b d=%h required 1 00000200", rv, d);
    end
  endtask

  initial begin
    Reset = 1'b0;
    hang = 1'b0;
    bus.Req_Valid = 1'b0;
    bus.Req_Op = 3'd0;
    bus.Req_A = '0;
    bus.Req_B = '0;
    bus.Flush = 1'b0;
    test_reset;
    test_mult;
    test_divu_stall;
    test_flush;
    test_flush_read;
    test_bad_op;
    test_timeout;
    test_reset_mid;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_assert, n_fail);
    $finish;
  end

endmodule
